// File: rtl/elem_pkg.sv
// Shared types for the per-element pulse player: playback modes, FSM states
// and the parameter payload that travels beside the envelope memory.
package elem_pkg;

  // Payload field widths; the top-level defaults must match these.
  localparam int AMP_W   = 16;
  localparam int FREQ_W  = 9;
  localparam int PHASE_W = 17;
  localparam int MODE_W  = 2;

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'd0,
    MODE_HOLD    = 2'd1,
    MODE_LOOP    = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  typedef struct packed {
    logic [AMP_W-1:0]   amp;
    logic [FREQ_W-1:0]  freq;
    logic [PHASE_W-1:0] phase;
    logic [MODE_W-1:0]  mode;
    logic               last;
  } payload_t;

  // Mode 11 is unassigned and plays as a one-shot.
  function automatic logic is_oneshot(input logic [MODE_W-1:0] m);
    return !((m == MODE_HOLD) || (m == MODE_LOOP));
  endfunction

endpackage

// File: rtl/elem_param_pipe.sv
// Delay line matching the envelope memory read latency; carries a valid bit
// and the command payload so both arrive together with the read data.
module elem_param_pipe
  import elem_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  input  logic     clear_last,
  input  logic     valid_in,
  input  payload_t din,
  output logic     valid_out,
  output payload_t dout,
  output logic     pending
);

  logic [DEPTH-1:0] v_q;
  payload_t         p_q     [DEPTH];
  payload_t         shift_d [DEPTH];

  // A pre-empting command strips the last tag from every sample still in flight.
  always_comb begin
    shift_d[0]      = din;
    shift_d[0].last = din.last && !clear_last;
    for (int i = 1; i < DEPTH; i++) begin
      shift_d[i]      = p_q[i-1];
      shift_d[i].last = p_q[i-1].last && !clear_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) p_q[i] <= '0;
    end else if (flush) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) p_q[i].last <= 1'b0;
    end else begin
      v_q[0] <= valid_in;
      for (int i = 1; i < DEPTH; i++) v_q[i] <= v_q[i-1];
      for (int i = 0; i < DEPTH; i++) p_q[i] <= shift_d[i];
    end
  end

  // Samples that will emit on a later cycle, i.e. excluding the output stage.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) pending = pending | v_q[i];
  end

  assign valid_out = v_q[DEPTH-1];
  assign dout      = p_q[DEPTH-1];

endmodule

// File: rtl/elem_pulse_player.sv
// Element-side pulse player: turns a core command into envelope reads and
// emits each returned word with the command parameters aligned to it.
module elem_pulse_player
  import elem_pkg::*;
#(
  parameter int ENV_ADDR_WIDTH = 12,
  parameter int ENV_DATA_WIDTH = 32,
  parameter int AMP_WIDTH      = AMP_W,
  parameter int FREQ_WIDTH     = FREQ_W,
  parameter int PHASE_WIDTH    = PHASE_W,
  parameter int MODE_WIDTH     = MODE_W,
  parameter int ENV_RD_LATENCY = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      elem_reset,
  input  logic                      cmdstb,
  input  logic [ENV_ADDR_WIDTH-1:0] envstart,
  input  logic [ENV_ADDR_WIDTH-1:0] envlength,
  input  logic [AMP_WIDTH-1:0]      ampx,
  input  logic [FREQ_WIDTH-1:0]     freqaddr,
  input  logic [PHASE_WIDTH-1:0]    pini,
  input  logic [MODE_WIDTH-1:0]     mode,
  output logic                      env_rd_en,
  output logic [ENV_ADDR_WIDTH-1:0] env_rd_addr,
  input  logic [ENV_DATA_WIDTH-1:0] env_rd_data,
  output logic                      sample_valid,
  output logic [ENV_DATA_WIDTH-1:0] sample_env,
  output logic [AMP_WIDTH-1:0]      sample_amp,
  output logic [FREQ_WIDTH-1:0]     sample_freq,
  output logic [PHASE_WIDTH-1:0]    sample_phase,
  output logic [MODE_WIDTH-1:0]     sample_mode,
  output logic                      busy,
  output logic                      done_stb,
  output state_e                    dbg_state
);

  // Handshake: no backpressure; each env_rd_en cycle returns one word exactly
  // ENV_RD_LATENCY cycles later, and sample_valid marks that word for one cycle.

  state_e                    state, state_d;
  logic [ENV_ADDR_WIDTH-1:0] start_q, len_q, cnt_q;
  logic [AMP_WIDTH-1:0]      amp_q;
  logic [FREQ_WIDTH-1:0]     freq_q;
  logic [PHASE_WIDTH-1:0]    phase_q;
  logic [MODE_WIDTH-1:0]     mode_q;
  logic                      cmd_go, cmd_zero, at_last, zero_done_q, busy_q;
  logic                      pipe_valid, pipe_pending;
  payload_t                  pipe_in, pipe_out;

  assign cmd_go   = cmdstb && !elem_reset && (envlength != '0);
  assign cmd_zero = cmdstb && !elem_reset && (envlength == '0);
  assign at_last  = (cnt_q == len_q - 1'b1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (elem_reset) begin
      state_d = ST_IDLE;
    end else if (cmdstb) begin
      state_d = (envlength != '0) ? ST_PLAY : ST_IDLE;
    end else begin
      case (state)
        ST_PLAY: begin
          if (at_last) begin
            if (mode_q == MODE_HOLD)      state_d = ST_HOLD;
            else if (mode_q == MODE_LOOP) state_d = ST_PLAY;
            else                          state_d = ST_DRAIN;
          end
        end
        ST_HOLD:  state_d = ST_HOLD;
        ST_DRAIN: if (!pipe_pending) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    env_rd_en     = (state == ST_PLAY) || (state == ST_HOLD);
    env_rd_addr   = start_q + cnt_q;
    pipe_in       = '0;
    pipe_in.amp   = amp_q;
    pipe_in.freq  = freq_q;
    pipe_in.phase = phase_q;
    pipe_in.mode  = mode_q;
    pipe_in.last  = (state == ST_PLAY) && at_last && is_oneshot(mode_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q     <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      amp_q       <= '0;
      freq_q      <= '0;
      phase_q     <= '0;
      mode_q      <= '0;
      zero_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (cmd_go) begin
        start_q <= envstart;
        len_q   <= envlength;
        amp_q   <= ampx;
        freq_q  <= freqaddr;
        phase_q <= pini;
        mode_q  <= mode;
        cnt_q   <= '0;
      end else if (state == ST_PLAY) begin
        // In hold and one-shot the counter parks on the last sample.
        if (!at_last)                cnt_q <= cnt_q + 1'b1;
        else if (mode_q == MODE_LOOP) cnt_q <= '0;
      end
      zero_done_q <= cmd_zero;
      busy_q      <= !elem_reset && ((state_d != ST_IDLE) || pipe_pending || pipe_valid);
    end
  end

  elem_param_pipe #(
    .DEPTH(ENV_RD_LATENCY)
  ) u_pipe (
    .clk       (clk),
    .rst       (reset),
    .flush     (elem_reset),
    .clear_last(cmdstb && !elem_reset),
    .valid_in  (env_rd_en),
    .din       (pipe_in),
    .valid_out (pipe_valid),
    .dout      (pipe_out),
    .pending   (pipe_pending)
  );

  assign sample_valid = pipe_valid;
  assign sample_env   = pipe_valid ? env_rd_data    : '0;
  assign sample_amp   = pipe_valid ? pipe_out.amp   : '0;
  assign sample_freq  = pipe_valid ? pipe_out.freq  : '0;
  assign sample_phase = pipe_valid ? pipe_out.phase : '0;
  assign sample_mode  = pipe_valid ? pipe_out.mode  : '0;
  assign done_stb     = zero_done_q || (pipe_valid && pipe_out.last);
  assign busy         = busy_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_elem_pulse_player.sv
// Bench for elem_pulse_player: directed scenarios plus random commands, checked
// cycle by cycle against a command-level model of reads and emitted samples.
module tb_elem_pulse_player;
  import elem_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int L  = 3;

  logic          clk = 1'b0;
  logic          reset, elem_reset, cmdstb;
  logic [AW-1:0] envstart, envlength;
  logic [15:0]   ampx;
  logic [8:0]    freqaddr;
  logic [16:0]   pini;
  logic [1:0]    mode;
  logic          env_rd_en;
  logic [AW-1:0] env_rd_addr;
  logic [DW-1:0] env_rd_data;
  logic          sample_valid;
  logic [DW-1:0] sample_env;
  logic [15:0]   sample_amp;
  logic [8:0]    sample_freq;
  logic [16:0]   sample_phase;
  logic [1:0]    sample_mode;
  logic          busy, done_stb;
  state_e        dbg_state;

  elem_pulse_player dut (
    .clk(clk), .reset(reset), .elem_reset(elem_reset), .cmdstb(cmdstb),
    .envstart(envstart), .envlength(envlength), .ampx(ampx), .freqaddr(freqaddr),
    .pini(pini), .mode(mode), .env_rd_en(env_rd_en), .env_rd_addr(env_rd_addr),
    .env_rd_data(env_rd_data), .sample_valid(sample_valid), .sample_env(sample_env),
    .sample_amp(sample_amp), .sample_freq(sample_freq), .sample_phase(sample_phase),
    .sample_mode(sample_mode), .busy(busy), .done_stb(done_stb), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a, 4'h5, ~a, 4'hC};
  endfunction

  // Envelope memory with a fixed read latency of L cycles.
  logic [AW-1:0] rd_hist [L];
  always @(posedge clk) begin
    rd_hist[0] <= env_rd_addr;
    for (int i = 1; i < L; i++) rd_hist[i] <= rd_hist[i-1];
  end
  assign env_rd_data = mem_word(rd_hist[L-1]);

  typedef struct {
    bit            valid;
    logic [AW-1:0] addr;
    logic [15:0]   amp;
    logic [8:0]    freq;
    logic [16:0]   phase;
    logic [1:0]    mode;
    bit            last;
  } rec_t;

  rec_t          log_q[$];
  rec_t          exp_rd, exp_s;
  bit            exp_busy, exp_done;
  bit            m_active, m_hold, m_zd;
  logic [AW-1:0] m_start, m_len, m_k;
  logic [15:0]   m_amp;
  logic [8:0]    m_freq;
  logic [16:0]   m_phase;
  logic [1:0]    m_mode;
  int            n_vec = 0;
  int            n_fail = 0;

  function automatic rec_t blank();
    rec_t r;
    r.valid = 0; r.addr = '0; r.amp = '0; r.freq = '0; r.phase = '0; r.mode = '0; r.last = 0;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compute_rd();
    exp_rd = blank();
    if (m_active) begin
      exp_rd.valid = 1;
      exp_rd.addr  = m_hold ? AW'(m_start + m_len - 12'd1) : AW'(m_start + m_k);
      exp_rd.amp   = m_amp;
      exp_rd.freq  = m_freq;
      exp_rd.phase = m_phase;
      exp_rd.mode  = m_mode;
      exp_rd.last  = !m_hold && (m_k == m_len - 12'd1) && (m_mode == 2'd0 || m_mode == 2'd3);
    end
  endtask

  task automatic model_reset();
    log_q.delete();
    for (int i = 0; i < L - 1; i++) log_q.push_back(blank());
    m_active = 0; m_hold = 0; m_zd = 0; m_k = '0;
    exp_s = blank(); exp_busy = 0; exp_done = 0;
    compute_rd();
  endtask

  task automatic model_step();
    bit anyv;
    log_q.push_back(exp_rd);
    if (exp_rd.valid && !m_hold) begin
      m_k = m_k + 12'd1;
      if (m_k == m_len) begin
        case (m_mode)
          2'd1:    m_hold = 1;
          2'd2:    m_k = '0;
          default: m_active = 0;
        endcase
      end
    end
    if (elem_reset) begin
      foreach (log_q[i]) begin log_q[i].valid = 0; log_q[i].last = 0; end
      m_active = 0; m_hold = 0; m_zd = 0;
    end else if (cmdstb) begin
      foreach (log_q[i]) log_q[i].last = 0;
      if (envlength != '0) begin
        m_active = 1; m_hold = 0; m_k = '0; m_zd = 0;
        m_start = envstart; m_len = envlength; m_amp = ampx;
        m_freq = freqaddr; m_phase = pini; m_mode = mode;
      end else begin
        m_active = 0; m_hold = 0; m_zd = 1;
      end
    end else begin
      m_zd = 0;
    end
    anyv = exp_s.valid;
    foreach (log_q[i]) if (log_q[i].valid) anyv = 1;
    exp_busy = !elem_reset && (m_active || anyv);
    exp_s    = log_q.pop_front();
    exp_done = m_zd || (exp_s.valid && exp_s.last);
    compute_rd();
  endtask

  task automatic check_outputs();
    chk("rd_en", 64'(env_rd_en), 64'(exp_rd.valid));
    if (exp_rd.valid) chk("rd_addr", 64'(env_rd_addr), 64'(exp_rd.addr));
    chk("sample_valid", 64'(sample_valid), 64'(exp_s.valid));
    if (exp_s.valid) begin
      chk("sample_env", 64'(sample_env), 64'(mem_word(exp_s.addr)));
      chk("sample_amp", 64'(sample_amp), 64'(exp_s.amp));
      chk("sample_freq", 64'(sample_freq), 64'(exp_s.freq));
      chk("sample_phase", 64'(sample_phase), 64'(exp_s.phase));
      chk("sample_mode", 64'(sample_mode), 64'(exp_s.mode));
    end
    chk("busy", 64'(busy), 64'(exp_busy));
    chk("done_stb", 64'(done_stb), 64'(exp_done));
  endtask

  task automatic tick();
    check_outputs();
    model_step();
    @(posedge clk);
    @(negedge clk);
    cmdstb = 0;
    elem_reset = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [AW-1:0] s, input logic [AW-1:0] len, input logic [1:0] m);
    cmdstb = 1; envstart = s; envlength = len; mode = m;
    ampx = 16'($urandom); freqaddr = 9'($urandom); pini = 17'($urandom);
    tick();
  endtask

  task automatic soft_reset();
    elem_reset = 1;
    tick();
  endtask

  task automatic async_reset();
    #2 reset = 1;
    #1;
    chk("async_rd_en", 64'(env_rd_en), 64'd0);
    chk("async_sample_valid", 64'(sample_valid), 64'd0);
    chk("async_busy", 64'(busy), 64'd0);
    chk("async_done", 64'(done_stb), 64'd0);
    chk("async_rd_addr", 64'(env_rd_addr), 64'd0);
    #1 reset = 0;
    model_reset();
  endtask

  initial begin
    reset = 1; elem_reset = 0; cmdstb = 0;
    envstart = '0; envlength = '0; ampx = '0; freqaddr = '0; pini = '0; mode = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_rd_en", 64'(env_rd_en), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    reset = 0;
    idle(2);

    // One-shot, then one-shot wrapping the address space.
    send(12'h010, 12'd4, 2'b00); idle(10);
    send(12'hFFE, 12'd4, 2'b00); idle(10);

    // Hold, then pre-empted by a single-sample one-shot.
    send(12'h100, 12'd2, 2'b01); idle(8);
    send(12'h200, 12'd1, 2'b00); idle(8);

    // Loop, stopped by a soft abort.
    send(12'h020, 12'd3, 2'b10); idle(9);
    soft_reset(); idle(6);

    // Zero-length command, mode 11, and abort racing a command.
    send(12'h055, 12'd0, 2'b00); idle(4);
    send(12'h060, 12'd3, 2'b11); idle(8);
    elem_reset = 1; send(12'h070, 12'd4, 2'b00); idle(5);

    // Pre-empting a draining one-shot strips its done.
    send(12'h080, 12'd3, 2'b00); idle(3);
    send(12'h090, 12'd0, 2'b00); idle(6);

    // Asynchronous reset in the middle of playback.
    send(12'h0A0, 12'd8, 2'b00); idle(3);
    async_reset();
    idle(1);
    send(12'h300, 12'd3, 2'b00); idle(8);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0:       soft_reset();
        1:       send(12'($urandom), 12'd0, 2'($urandom));
        2:       begin elem_reset = 1; send(12'($urandom), 12'($urandom_range(1, 6)), 2'($urandom)); end
        default: send(12'($urandom), 12'($urandom_range(1, 6)), 2'($urandom));
      endcase
      idle($urandom_range(0, 10));
    end
    soft_reset();
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
